// File: rtl/snake_control_if.sv
// snake_control_if: control-side bundle between snake FSM and datapath/VGA.
// Inputs: go, key_up/down/left/right. Outputs: ld, update, plot, dir[2:0], colour[2:0].
interface snake_control_if;
  logic       go;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       ld;
  logic       update;
  logic       plot;
  logic [2:0] dir;
  logic [2:0] colour;

  modport master (
    output go, key_up, key_down, key_left, key_right,
    input  ld, update, plot, dir, colour
  );

  modport slave (
    input  go, key_up, key_down, key_left, key_right,
    output ld, update, plot, dir, colour
  );
endinterface

// File: rtl/snake_control.sv
// snake_control: load/draw/wait/erase/update sequencer for the snake head.
// Ports: clk, reset (sync, active-high), sc (slave: go/keys in; ld/update/plot/dir/colour out).
module snake_control #(
  parameter int          TICKS        = 833333,
  parameter int          CELL_PIX     = 8,
  parameter logic [2:0]  SNAKE_COLOUR = 3'b010
) (
  input  logic            clk,
  input  logic            reset,
  snake_control_if.slave  sc
);

  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int PW = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(CELL_PIX - 1);

  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_UPDATE
  } state_e;

  state_e        state_q;
  logic [TW-1:0] tick_q;
  logic [PW-1:0] pix_q;
  logic          ld_q;
  logic          update_q;
  logic          plot_q;
  logic [2:0]    colour_q;
  logic [2:0]    dir_q;
  logic [2:0]    dir_d;
  logic [2:0]    cur_dir_q;

  // Outputs are registered together with the state they belong to,
  // so each strobe lines up exactly with its state's cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      pix_q     <= '0;
      ld_q      <= 1'b0;
      update_q  <= 1'b0;
      plot_q    <= 1'b0;
      colour_q  <= 3'b000;
      cur_dir_q <= DIR_RIGHT;
    end else begin
      ld_q     <= 1'b0;
      update_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sc.go) begin
            state_q <= S_LOAD;
            ld_q    <= 1'b1;
          end
        end
        S_LOAD: begin
          pix_q    <= '0;
          state_q  <= S_DRAW;
          plot_q   <= 1'b1;
          colour_q <= SNAKE_COLOUR;
        end
        S_DRAW: begin
          if (pix_q == PIX_LAST) begin
            pix_q    <= '0;
            state_q  <= S_WAIT;
            plot_q   <= 1'b0;
            colour_q <= 3'b000;
          end else begin
            pix_q <= pix_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (tick_q == TICK_LAST) begin
            tick_q   <= '0;
            state_q  <= S_ERASE;
            plot_q   <= 1'b1;
            colour_q <= 3'b000;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_ERASE: begin
          if (pix_q == PIX_LAST) begin
            pix_q    <= '0;
            state_q  <= S_UPDATE;
            plot_q   <= 1'b0;
            update_q <= 1'b1;
          end else begin
            pix_q <= pix_q + 1'b1;
          end
        end
        S_UPDATE: begin
          // dir_q is what the datapath steps with this cycle.
          cur_dir_q <= dir_q;
          state_q   <= S_DRAW;
          plot_q    <= 1'b1;
          colour_q  <= SNAKE_COLOUR;
        end
        default: begin
          state_q  <= S_IDLE;
          plot_q   <= 1'b0;
          colour_q <= 3'b000;
        end
      endcase
    end
  end

  // Priority up > down > left > right is applied before the reversal
  // test, so a rejected higher key masks lower ones.
  always_comb begin
    dir_d = dir_q;
    if (sc.key_up) begin
      if (cur_dir_q != DIR_DOWN) dir_d = DIR_UP;
    end else if (sc.key_down) begin
      if (cur_dir_q != DIR_UP) dir_d = DIR_DOWN;
    end else if (sc.key_left) begin
      if (cur_dir_q != DIR_RIGHT) dir_d = DIR_LEFT;
    end else if (sc.key_right) begin
      if (cur_dir_q != DIR_LEFT) dir_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= DIR_RIGHT;
    end else begin
      dir_q <= dir_d;
    end
  end

  assign sc.ld     = ld_q;
  assign sc.update = update_q;
  assign sc.plot   = plot_q;
  assign sc.colour = colour_q;
  assign sc.dir    = dir_q;

endmodule

// File: tb/tb_snake_control.sv
// tb_snake_control: directed scoreboard bench for snake_control.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_snake_control;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  snake_control_if bus ();

  snake_control #(
    .TICKS       (4),
    .CELL_PIX    (8),
    .SNAKE_COLOUR(3'b010)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sc   (bus.slave)
  );

  typedef struct {
    logic       ld;
    logic       upd;
    logic       plot;
    logic [2:0] dir;
    logic [2:0] col;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [2:0] R  = 3'b001;
  localparam logic [2:0] D  = 3'b110;
  localparam logic [2:0] U  = 3'b100;
  localparam logic [2:0] G  = 3'b010;
  localparam logic [2:0] C0 = 3'b000;

  localparam logic [3:0] K0  = 4'b0000;
  localparam logic [3:0] KUP = 4'b1000;
  localparam logic [3:0] KDN = 4'b0100;
  localparam logic [3:0] KLF = 4'b0010;

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic cyc(input logic r, input logic g, input logic [3:0] k,
                     input logic l, input logic u, input logic p,
                     input logic [2:0] d, input logic [2:0] c,
                     input string t);
    exp_t e;
    @(negedge clk);
    reset = r;
    bus.go = g;
    {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
    e.ld = l;
    e.upd = u;
    e.plot = p;
    e.dir = d;
    e.col = c;
    e.tag = t;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per cycle, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.ld !== e.ld || bus.update !== e.upd || bus.plot !== e.plot ||
          bus.dir !== e.dir || bus.colour !== e.col ||
          !$onehot0({bus.ld, bus.update, bus.plot})) begin
        failures++;
        $display("FAIL %s: got ld=%b upd=%b plot=%b dir=%b col=%b exp ld=%b upd=%b plot=%b dir=%b col=%b",
                 e.tag, bus.ld, bus.update, bus.plot, bus.dir, bus.colour,
                 e.ld, e.upd, e.plot, e.dir, e.col);
      end
    end
  end

  always @(negedge clk) begin
    assert ($onehot0({bus.ld, bus.update, bus.plot}))
      else $error("strobes overlap");
  end

  initial begin
    logic [3:0] k;
    logic [2:0] d;
    reset = 1'b1;
    bus.go = 1'b0;
    bus.key_up = 1'b0;
    bus.key_down = 1'b0;
    bus.key_left = 1'b0;
    bus.key_right = 1'b0;

    repeat (2) cyc(1, 0, K0, 0, 0, 0, R, C0, "reset");
    repeat (10) cyc(0, 0, K0, 0, 0, 0, R, C0, "idle");

    // Loop 1: left alone rejected, left+up accepted, down during WAIT.
    cyc(0, 1, K0, 1, 0, 0, R, C0, "load1");
    for (int i = 0; i < 8; i++) begin
      k = (i == 2) ? KLF : (i == 4) ? (KLF | KUP) : K0;
      d = (i < 4) ? R : U;
      cyc(0, 0, k, 0, 0, 1, d, G, "draw1");
    end
    for (int i = 0; i < 4; i++) begin
      k = (i == 1) ? KDN : K0;
      d = (i >= 1) ? D : U;
      cyc(0, 0, k, 0, 0, 0, d, C0, "wait1");
    end
    repeat (8) cyc(0, 0, K0, 0, 0, 1, D, C0, "erase1");
    cyc(0, 0, K0, 0, 1, 0, D, C0, "update1");

    // Loop 2: go held high, reversal key_up rejected.
    for (int i = 0; i < 8; i++) begin
      k = (i == 1 || i == 2) ? KUP : K0;
      cyc(0, 1, k, 0, 0, 1, D, G, "draw2");
    end
    repeat (4) cyc(0, 1, K0, 0, 0, 0, D, C0, "wait2");
    repeat (8) cyc(0, 1, K0, 0, 0, 1, D, C0, "erase2");
    cyc(0, 1, K0, 0, 1, 0, D, C0, "update2");

    // Loop 3: reset during the third DRAW cycle, then restart.
    repeat (3) cyc(0, 0, K0, 0, 0, 1, D, G, "draw3");
    cyc(1, 0, K0, 0, 0, 0, R, C0, "reset_mid");
    cyc(0, 0, K0, 0, 0, 0, R, C0, "idle2");
    cyc(0, 1, K0, 1, 0, 0, R, C0, "reload");
    cyc(0, 0, K0, 0, 0, 1, R, G, "draw4");

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_control.md
Name: snake_control

Overview:
- Control FSM for the snake head datapath. It drives that stage's ld, update, plot and dir inputs.
- Sequences a repeating cycle: load, draw head cell, wait one move period, erase cell, step position, draw again.
- Supplies the pixel colour to the VGA adapter alongside the datapath's x/y.
- Converts four push-button direction requests into the datapath's 3-bit direction code and rejects 180° reversals.

Parameters:
- TICKS, 833333: clock cycles spent in WAIT per move (60 Hz at 50 MHz).
- CELL_PIX, 8: plot cycles per draw or erase pass. Must equal the datapath's per-cell pixel count (its 3-bit counter wraps after 8).
- SNAKE_COLOUR, 3'b010: colour output during DRAW.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  start request; sampled only in IDLE
- key_up  in  1  direction request, level-sensitive
- key_down  in  1  direction request
- key_left  in  1  direction request
- key_right  in  1  direction request
- ld  out  1  datapath load-initial-position strobe
- update  out  1  datapath move-one-step strobe
- plot  out  1  datapath/VGA pixel write enable
- dir  out  3  direction code to datapath
- colour  out  3  VGA pixel colour

Behaviour:
- Single clock domain. All state changes on posedge clk.
- Reset is synchronous and active-high. It has priority over everything, including mid-pass. Reset state:
  - state = IDLE
  - ld = update = plot = 0, colour = 0
  - dir = cur_dir = 3'b001 (RIGHT)
  - tick and pixel counters = 0
- Direction codes (fixed by the datapath):
  - RIGHT = 001 (x+1)
  - LEFT = 000 (x−1)
  - DOWN = 110 (y+1)
  - UP = 100 (y−1)
- Outputs are decoded from the state register (Moore), so each output is valid in the same cycle as its state.
- States and transitions:
  - IDLE: all strobes 0. If go = 1, go to LOAD; otherwise stay.
  - LOAD: ld = 1 for exactly 1 cycle. Pixel counter cleared. Go to DRAW.
  - DRAW: plot = 1, colour = SNAKE_COLOUR, for exactly CELL_PIX consecutive cycles. Pixel counter increments each cycle. At count CELL_PIX−1, clear counter and go to WAIT.
  - WAIT: plot = 0, colour = 0. Tick counter increments each cycle. At count TICKS−1, clear counter and go to ERASE. WAIT lasts exactly TICKS cycles.
  - ERASE: plot = 1, colour = 3'b000, for exactly CELL_PIX cycles. Then go to UPDATE.
  - UPDATE: update = 1 for exactly 1 cycle. cur_dir <= dir. Go to DRAW.
- Steady-state period, from one DRAW entry to the next: 2·CELL_PIX + TICKS + 1 cycles.
- Direction capture (dir register):
  - Sampled every cycle except during reset.
  - Priority when several keys are high: up > down > left > right.
  - A request is ignored if it is the reverse of cur_dir: UP vs DOWN, LEFT vs RIGHT.
  - Otherwise dir <= the requested code. The last accepted request before UPDATE wins.
  - No key pressed: dir holds.
- dir is stable throughout UPDATE. The datapath consumes it in that cycle.
- go is ignored outside IDLE. There is no return to IDLE except via reset.
- Tick counter width: $clog2(TICKS), minimum 1. Pixel counter width: $clog2(CELL_PIX), minimum 1. Counters never exceed their terminal values.
- ld, update and plot are mutually exclusive in every cycle.

Test Plan (TICKS=4, CELL_PIX=8):
- Reset held 2 cycles, then released with go = 0 for 10 cycles -> all outputs 0, dir = 001, no strobes.
- go pulsed 1 cycle -> ld high for exactly 1 cycle. Next 8 cycles: plot = 1, colour = 010. Then 4 cycles plot = 0. Then 8 cycles plot = 1, colour = 000. Then update = 1 for 1 cycle. Then plot = 1 again. Period = 21 cycles.
- key_down asserted during WAIT -> dir = 110 at the UPDATE cycle. cur_dir becomes 110. A later key_up is ignored; dir stays 110.
- cur_dir = 001, key_left pressed alone -> dir stays 001. key_left and key_up pressed together -> dir = 100.
- Reset asserted in the 3rd DRAW cycle -> next cycle state IDLE, plot = 0, dir = 001. Re-issuing go produces a fresh ld.
- go held high for an entire loop -> no extra ld pulses. Strobes never overlap (checked by assertion every cycle).
